ppu_cpu_regs: RTL and testbench

- CPU-facing register responder of the PPU. Services CPU bus accesses decoded to $2000-$3FFF (eight registers mirrored via a[2:0]), holds PPUCTRL/PPUMASK/scroll/VRAM address state and 256-byte OAM.
- Drives the NMI line. Performs PPUDATA traffic to VRAM through a req/ack port.
- Sits between the CPU address/data bus decode and the PPU render/VRAM logic.

---
 rtl/ppu_cpu_regs.sv | 192 +++++++++++++++++++
 tb/tb_ppu_cpu_regs.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ppu_cpu_regs.sv
// ppu_cpu_regs: CPU-facing PPU register block ($2000-$3FFF, mirrored on a[2:0]).
// Holds control/scroll/VRAM address state, OAM, status flags, NMI and the PPUDATA VRAM port.
module ppu_cpu_regs #(
    parameter int OAM_AW  = 8,
    parameter int VADDR_W = 14
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cs_n,
    input  logic               rnw,
    input  logic [2:0]         a,
    input  logic [7:0]         db_in,
    output logic [7:0]         db_out,
    output logic               db_oe,
    output logic               nmi_n,
    input  logic               vblank_set,
    input  logic               frame_clr,
    input  logic               spr0_hit_set,
    input  logic               spr_ovf_set,
    output logic [7:0]         ctrl,
    output logic [7:0]         mask,
    output logic [14:0]        v,
    output logic [14:0]        t,
    output logic [2:0]         fine_x,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    input  logic               vram_ack,
    output logic               vram_overrun
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t st_q, st_d;
    logic cs_q, w_q, w_d, vbl_q, vbl_d, spr0_q, spr0_d, ovf_q, ovf_d;
    logic req_q, req_d, we_q, we_d, ovr_q, ovr_d, oam_we;
    logic [7:0] ctrl_q, ctrl_d, mask_q, mask_d, latch_q, latch_d, dbo_q, dbo_d;
    logic [7:0] rdbuf_q, rdbuf_d, wdata_q, wdata_d, rd_val;
    logic [14:0] v_q, v_d, t_q, t_d;
    logic [2:0] fx_q, fx_d;
    logic [OAM_AW-1:0] oamaddr_q, oamaddr_d;
    logic [VADDR_W-1:0] addr_q, addr_d;
    logic [7:0] oam_q [2**OAM_AW];
    logic access, wr, rd;
    // An access begins on the first cycle cs_n is seen low after being high.
    assign access = cs_q & ~cs_n;
    assign wr = access & ~rnw;
    assign rd = access & rnw;
    assign rd_val = (a == 3'd2) ? {vbl_q, spr0_q, ovf_q, latch_q[4:0]} :
                    (a == 3'd4) ? oam_q[oamaddr_q] :
                    (a == 3'd7) ? rdbuf_q : latch_q;
    always_comb begin
        ctrl_d = ctrl_q;
        mask_d = mask_q;
        v_d = v_q;
        t_d = t_q;
        fx_d = fx_q;
        w_d = w_q;
        oamaddr_d = oamaddr_q;
        latch_d = latch_q;
        dbo_d = dbo_q;
        rdbuf_d = rdbuf_q;
        st_d = st_q;
        req_d = req_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        ovr_d = ovr_q;
        oam_we = 1'b0;
        if (rd) begin
            dbo_d = rd_val;
            latch_d = rd_val;
        end
        if (wr) latch_d = db_in;
        if (wr) begin
            case (a)
                3'd0: begin
                    ctrl_d = db_in;
                    t_d[11:10] = db_in[1:0];
                end
                3'd1: mask_d = db_in;
                3'd3: oamaddr_d = OAM_AW'(db_in);
                3'd4: begin
                    oam_we = 1'b1;
                    oamaddr_d = oamaddr_q + OAM_AW'(1);
                end
                3'd5: begin
                    if (!w_q) begin
                        t_d[4:0] = db_in[7:3];
                        fx_d = db_in[2:0];
                    end else begin
                        t_d[14:12] = db_in[2:0];
                        t_d[9:5] = db_in[7:3];
                    end
                    w_d = ~w_q;
                end
                3'd6: begin
                    if (!w_q) begin
                        t_d[13:8] = db_in[5:0];
                        t_d[14] = 1'b0;
                    end else begin
                        t_d[7:0] = db_in;
                        v_d = {t_q[14:8], db_in};
                    end
                    w_d = ~w_q;
                end
                default: ;
            endcase
        end
        if (rd && a == 3'd2) w_d = 1'b0;
        if (st_q == S_WAIT && vram_ack) begin
            req_d = 1'b0;
            st_d = S_IDLE;
            if (!we_q) rdbuf_d = vram_rdata;
        end
        // PPUDATA while a request is outstanding is dropped and flagged.
        if (access && a == 3'd7) begin
            if (st_q == S_IDLE) begin
                req_d = 1'b1;
                we_d = ~rnw;
                addr_d = v_q[VADDR_W-1:0];
                wdata_d = rnw ? wdata_q : db_in;
                v_d = v_q + (ctrl_q[2] ? 15'd32 : 15'd1);
                st_d = S_WAIT;
            end else ovr_d = 1'b1;
        end
    end
    assign vbl_d = frame_clr ? 1'b0 : (vbl_q | vblank_set) & ~(rd && a == 3'd2);
    assign spr0_d = ~frame_clr & (spr0_q | spr0_hit_set);
    assign ovf_d = ~frame_clr & (ovf_q | spr_ovf_set);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_q <= 1'b1;
            ctrl_q <= '0;
            mask_q <= '0;
            v_q <= '0;
            t_q <= '0;
            fx_q <= '0;
            w_q <= 1'b0;
            oamaddr_q <= '0;
            latch_q <= '0;
            dbo_q <= '0;
            rdbuf_q <= '0;
            vbl_q <= 1'b0;
            spr0_q <= 1'b0;
            ovf_q <= 1'b0;
            st_q <= S_IDLE;
            req_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            cs_q <= cs_n;
            ctrl_q <= ctrl_d;
            mask_q <= mask_d;
            v_q <= v_d;
            t_q <= t_d;
            fx_q <= fx_d;
            w_q <= w_d;
            oamaddr_q <= oamaddr_d;
            latch_q <= latch_d;
            dbo_q <= dbo_d;
            rdbuf_q <= rdbuf_d;
            vbl_q <= vbl_d;
            spr0_q <= spr0_d;
            ovf_q <= ovf_d;
            st_q <= st_d;
            req_q <= req_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            ovr_q <= ovr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (oam_we) oam_q[oamaddr_q] <= db_in;
    end
    assign db_out = dbo_q;
    assign db_oe = rnw & ~cs_n & ~cs_q;
    assign nmi_n = ~(vbl_q & ctrl_q[7]);
    assign ctrl = ctrl_q;
    assign mask = mask_q;
    assign v = v_q;
    assign t = t_q;
    assign fine_x = fx_q;
    assign vram_req = req_q;
    assign vram_we = we_q;
    assign vram_addr = addr_q;
    assign vram_wdata = wdata_q;
    assign vram_overrun = ovr_q;
endmodule

// File: tb/tb_ppu_cpu_regs.sv
// tb_ppu_cpu_regs: directed register-access sequence for ppu_cpu_regs.
module tb_ppu_cpu_regs;
    logic clk, rstn, cs_n, rnw, db_oe, nmi_n;
    logic vblank_set, frame_clr, spr0_hit_set, spr_ovf_set;
    logic [2:0] a, fine_x;
    logic [7:0] db_in, db_out, ctrl, mask, vram_wdata, vram_rdata;
    logic [14:0] v, t;
    logic [13:0] vram_addr;
    logic vram_req, vram_we, vram_ack, vram_overrun;
    logic [7:0] q;
    logic oe;
    int npass = 0, ntotal = 0;

    ppu_cpu_regs dut (
        .clk(clk), .rstn(rstn), .cs_n(cs_n), .rnw(rnw), .a(a), .db_in(db_in),
        .db_out(db_out), .db_oe(db_oe), .nmi_n(nmi_n), .vblank_set(vblank_set),
        .frame_clr(frame_clr), .spr0_hit_set(spr0_hit_set), .spr_ovf_set(spr_ovf_set),
        .ctrl(ctrl), .mask(mask), .v(v), .t(t), .fine_x(fine_x),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
        .vram_overrun(vram_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        ntotal++;
        assert (o === e) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, o, e);
    endtask

    // One bus access; q/oe are sampled in the cycle after the access starts.
    task automatic acc(input logic r, input logic [2:0] ad, input logic [7:0] d,
                       input logic vbs, output logic [7:0] dq, output logic doe);
        cs_n = 1'b0; rnw = r; a = ad; db_in = d; vblank_set = vbs;
        @(posedge clk); #1;
        vblank_set = 1'b0;
        dq = db_out; doe = db_oe;
        cs_n = 1'b1; rnw = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [7:0] d);
        logic [7:0] dq;
        logic doe;
        acc(1'b0, ad, d, 1'b0, dq, doe);
    endtask

    task automatic pulse(input logic vs, input logic fc, input logic s0, input logic ov);
        vblank_set = vs; frame_clr = fc; spr0_hit_set = s0; spr_ovf_set = ov;
        @(posedge clk); #1;
        vblank_set = 1'b0; frame_clr = 1'b0; spr0_hit_set = 1'b0; spr_ovf_set = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        vram_rdata = d; vram_ack = 1'b1;
        @(posedge clk); #1;
        vram_ack = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; cs_n = 1'b1; rnw = 1'b1; a = '0; db_in = '0;
        vblank_set = 1'b0; frame_clr = 1'b0; spr0_hit_set = 1'b0; spr_ovf_set = 1'b0;
        vram_rdata = '0; vram_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", ctrl, 8'h00);
        chk("rst_mask", mask, 8'h00);
        chk("rst_v", v, 15'h0);
        chk("rst_t", t, 15'h0);
        chk("rst_nmi", nmi_n, 1'b1);
        chk("rst_oe", db_oe, 1'b0);
        chk("rst_dbout", db_out, 8'h00);
        chk("rst_req", vram_req, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Buffered PPUDATA reads
        wr(3'd6, 8'h21);
        wr(3'd6, 8'h06);
        chk("v_2106", v, 15'h2106);
        chk("t_2106", t, 15'h2106);
        acc(1'b1, 3'd7, 8'h00, 1'b0, q, oe);
        chk("rd7_first", q, 8'h00);
        chk("rd7_oe", oe, 1'b1);
        chk("rd7_req", vram_req, 1'b1);
        chk("rd7_we", vram_we, 1'b0);
        chk("rd7_addr1", vram_addr, 14'h2106);
        chk("rd7_vinc", v, 15'h2107);
        ack(8'hAB);
        chk("ack_drop", vram_req, 1'b0);
        acc(1'b1, 3'd7, 8'h00, 1'b0, q, oe);
        chk("rd7_second", q, 8'hAB);
        chk("rd7_addr2", vram_addr, 14'h2107);
        ack(8'hCD);

        // PPUDATA write with increment 32
        wr(3'd0, 8'h04);
        wr(3'd6, 8'h20);
        wr(3'd6, 8'h00);
        wr(3'd7, 8'h55);
        chk("wr7_req", vram_req, 1'b1);
        chk("wr7_we", vram_we, 1'b1);
        chk("wr7_addr", vram_addr, 14'h2000);
        chk("wr7_wdata", vram_wdata, 8'h55);
        chk("wr7_vinc32", v, 15'h2020);
        ack(8'h00);
        chk("wr7_done", vram_req, 1'b0);

        // Scroll writes
        wr(3'd5, 8'h7D);
        wr(3'd5, 8'h5E);
        chk("scroll_t", t, 15'h616F);
        chk("scroll_fx", fine_x, 3'd5);
        chk("scroll_w", dut.w_q, 1'b0);

        // vblank / NMI / status read
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("nmi_masked", nmi_n, 1'b1);
        wr(3'd0, 8'h80);
        chk("nmi_ctrl_rise", nmi_n, 1'b0);
        wr(3'd5, 8'h1F);
        chk("w_set", dut.w_q, 1'b1);
        acc(1'b1, 3'd2, 8'h00, 1'b0, q, oe);
        chk("rd2_vbl", q, 8'h9F);
        chk("rd2_nmi_clr", nmi_n, 1'b1);
        chk("rd2_w_clr", dut.w_q, 1'b0);
        acc(1'b1, 3'd2, 8'h00, 1'b1, q, oe);
        chk("rd2_race_val", q, 8'h1F);
        chk("rd2_race_nmi", nmi_n, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        acc(1'b1, 3'd2, 8'h00, 1'b0, q, oe);
        chk("rd2_spr", q, 8'h7F);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("frame_clr_prio_nmi", nmi_n, 1'b1);
        acc(1'b1, 3'd2, 8'h00, 1'b0, q, oe);
        chk("rd2_cleared", q, 8'h1F);

        // OAM
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'h11);
        wr(3'd4, 8'h22);
        chk("oamaddr_wrap", dut.oamaddr_q, 8'h01);
        wr(3'd3, 8'h00);
        acc(1'b1, 3'd4, 8'h00, 1'b0, q, oe);
        chk("oam_00", q, 8'h22);
        wr(3'd3, 8'hFF);
        acc(1'b1, 3'd4, 8'h00, 1'b0, q, oe);
        chk("oam_ff", q, 8'h11);
        acc(1'b1, 3'd1, 8'h00, 1'b0, q, oe);
        chk("openbus_r1", q, 8'h11);

        // Overrun and async reset mid-request
        wr(3'd6, 8'h3F);
        wr(3'd6, 8'h00);
        acc(1'b1, 3'd7, 8'h00, 1'b0, q, oe);
        chk("ov_rdbuf", q, 8'hCD);
        chk("ov_v1", v, 15'h3F01);
        wr(3'd7, 8'h99);
        chk("ov_req", vram_req, 1'b1);
        chk("ov_addr", vram_addr, 14'h3F00);
        chk("ov_we", vram_we, 1'b0);
        chk("ov_v", v, 15'h3F01);
        chk("ov_flag", vram_overrun, 1'b1);
        rstn = 1'b0;
        #1;
        chk("arst_req", vram_req, 1'b0);
        chk("arst_ovr", vram_overrun, 1'b0);
        chk("arst_v", v, 15'h0);
        chk("arst_ctrl", ctrl, 8'h00);
        @(posedge clk); #1;
        rstn = 1'b1;
        ack(8'hEE);
        chk("late_ack_req", vram_req, 1'b0);
        acc(1'b1, 3'd7, 8'h00, 1'b0, q, oe);
        chk("late_ack_rdbuf", q, 8'h00);
        chk("post_rst_req", vram_req, 1'b1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
